// File: rtl/event_counter_bank_pkg.sv
// Shared constants and types for the event counter bank and its channels.
// Step direction and limit mode are enums so the channel logic reads in terms of UP/DOWN and WRAP/SAT.
package event_counter_bank_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_NUM_CH     = 4;
   localparam int DEFAULT_SEL_WIDTH  = 2;

   typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_e;
   typedef enum logic {WRAP = 1'b0, SAT = 1'b1} mode_e;

   typedef enum logic [1:0] {
      ACT_HOLD  = 2'd0,
      ACT_COUNT = 2'd1,
      ACT_LOAD  = 2'd2,
      ACT_CLEAR = 2'd3
   } action_e;

   // Per-edge channel action, priority clear > load > count > hold.
   function automatic action_e decode_action(input logic clear, input logic load, input logic enable);
      if (clear)       return ACT_CLEAR;
      else if (load)   return ACT_LOAD;
      else if (enable) return ACT_COUNT;
      else             return ACT_HOLD;
   endfunction

endpackage

// File: rtl/event_counter_bank_if.sv
// Control, status and readback bundle of the event counter bank.
// The master side drives the controls; the slave side is the counter bank.
interface event_counter_bank_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_CH     = 4,
   parameter int SEL_WIDTH  = 2
);

   logic [NUM_CH-1:0]     i_enable;
   logic [NUM_CH-1:0]     i_down;
   logic [NUM_CH-1:0]     i_clear;
   logic [NUM_CH-1:0]     i_load;
   logic [DATA_WIDTH-1:0] i_load_value;
   logic [DATA_WIDTH-1:0] i_compare_value;
   logic [NUM_CH-1:0]     i_ovf_ack;
   logic                  i_snapshot;
   logic [SEL_WIDTH-1:0]  i_rd_sel;
   logic [DATA_WIDTH-1:0] o_rd_data;
   logic [NUM_CH-1:0]     o_match;
   logic [NUM_CH-1:0]     o_overflow;

   modport master (
      output i_enable, i_down, i_clear, i_load, i_load_value, i_compare_value,
             i_ovf_ack, i_snapshot, i_rd_sel,
      input  o_rd_data, o_match, o_overflow
   );

   modport slave (
      input  i_enable, i_down, i_clear, i_load, i_load_value, i_compare_value,
             i_ovf_ack, i_snapshot, i_rd_sel,
      output o_rd_data, o_match, o_overflow
   );

endinterface

// File: rtl/event_counter_bank_counter_channel.sv
// One up/down event counter: clear/load/count priority, sticky overflow flag
// and a registered compare-match pulse raised only by count steps.
module counter_channel
   import event_counter_bank_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int SATURATE   = 0
) (
   input  logic                  clock,
   input  logic                  i_reset,
   input  logic                  enable,
   input  logic                  down,
   input  logic                  clear,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_value,
   input  logic [DATA_WIDTH-1:0] compare_value,
   input  logic                  ovf_ack,
   output logic [DATA_WIDTH-1:0] count,
   output logic                  match,
   output logic                  overflow
);

   localparam mode_e                 MODE    = (SATURATE != 0) ? SAT : WRAP;
   localparam logic [DATA_WIDTH-1:0] ONE     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DATA_WIDTH-1:0] ALL_ONE = '1;

   action_e               action;
   dir_e                  dir;
   logic                  at_limit;
   logic                  blocked;
   logic [DATA_WIDTH-1:0] stepped;

   // A step at the limit is an overflow in both modes; saturate mode also blocks it.
   always_comb begin
      action   = decode_action(clear, load, enable);
      dir      = dir_e'(down);
      at_limit = (dir == UP) ? (count == ALL_ONE) : (count == '0);
      blocked  = at_limit && (MODE == SAT);
      stepped  = (dir == UP) ? (count + ONE) : (count - ONE);
      if (blocked) begin
         stepped = count;
      end
   end

   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         count    <= '0;
         match    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         match <= 1'b0;
         case (action)
            ACT_CLEAR: count <= '0;
            ACT_LOAD:  count <= load_value;
            ACT_COUNT: begin
               count <= stepped;
               match <= !blocked && (stepped == compare_value);
            end
            default:   count <= count;
         endcase
         if ((action == ACT_COUNT) && at_limit) begin
            overflow <= 1'b1;
         end else if (ovf_ack || clear) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/event_counter_bank.sv
// Bank of independent event counters with a coherent snapshot into shadow
// registers and a registered, muxed shadow readback port.
module event_counter_bank
   import event_counter_bank_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int NUM_CH     = DEFAULT_NUM_CH,
   parameter int SEL_WIDTH  = DEFAULT_SEL_WIDTH,
   parameter int SATURATE   = 0
) (
   input  logic               clock,
   input  logic               i_reset,
   event_counter_bank_if.slave bus
);

   localparam int unsigned DEPTH = 2 ** SEL_WIDTH;

   logic [DATA_WIDTH-1:0] counts     [NUM_CH];
   logic [DATA_WIDTH-1:0] counts_ext [DEPTH];
   logic [DATA_WIDTH-1:0] shadow     [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data;
   logic [NUM_CH-1:0]     match_v;
   logic [NUM_CH-1:0]     overflow_v;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      counter_channel #(
         .DATA_WIDTH (DATA_WIDTH),
         .SATURATE   (SATURATE)
      ) u_channel (
         .clock         (clock),
         .i_reset       (i_reset),
         .enable        (bus.i_enable[i]),
         .down          (bus.i_down[i]),
         .clear         (bus.i_clear[i]),
         .load          (bus.i_load[i]),
         .load_value    (bus.i_load_value),
         .compare_value (bus.i_compare_value),
         .ovf_ack       (bus.i_ovf_ack[i]),
         .count         (counts[i]),
         .match         (match_v[i]),
         .overflow      (overflow_v[i])
      );
   end

   // Shadow array covers every select code; slots past NUM_CH stay 0, so
   // out-of-range selects read 0 without a separate range compare.
   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         counts_ext[i] = '0;
      end
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         counts_ext[i] = counts[i];
      end
   end

   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         shadow  <= '{default: '0};
         rd_data <= '0;
      end else begin
         if (bus.i_snapshot) begin
            shadow <= counts_ext;
         end
         rd_data <= shadow[bus.i_rd_sel];
      end
   end

   assign bus.o_rd_data  = rd_data;
   assign bus.o_match    = match_v;
   assign bus.o_overflow = overflow_v;

endmodule

// File: doc/event_counter_bank.md
Name: event_counter_bank

Overview:
- Bank of NUM_CH independent up/down event counters, DATA_WIDTH bits each.
- Every channel has enable, synchronous clear, parallel load, compare-match pulse and sticky overflow flag.
- A global snapshot freezes all channels' counts into shadow registers for coherent readback through one muxed read port.
- Serves as the general-purpose measurement counter block for switch/event counting and timing in the test designs.

Parameters:
- DATA_WIDTH, 32: counter width per channel.
- NUM_CH, 4: number of channels (1..16).
- SEL_WIDTH, 2: read-select width; must satisfy 2^SEL_WIDTH >= NUM_CH.
- SATURATE, 0: 0 = wrap-around at limits, 1 = hold at limits.

Ports:
- clock  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_enable  input  NUM_CH  per-channel count enable (one step per cycle).
- i_down  input  NUM_CH  per-channel direction: 0 = up, 1 = down.
- i_clear  input  NUM_CH  per-channel synchronous clear.
- i_load  input  NUM_CH  per-channel synchronous load of i_load_value.
- i_load_value  input  DATA_WIDTH  shared load value.
- i_compare_value  input  DATA_WIDTH  shared compare value.
- i_ovf_ack  input  NUM_CH  per-channel overflow flag clear.
- i_snapshot  input  1  capture all counts into shadow registers.
- i_rd_sel  input  SEL_WIDTH  shadow register select.
- o_rd_data  output  DATA_WIDTH  selected shadow value, registered.
- o_match  output  NUM_CH  one-cycle compare-match pulse per channel.
- o_overflow  output  NUM_CH  sticky overflow flag per channel.

Behaviour:
- Reset: i_reset, asynchronous, active-high; clock clock.
- Reset values: all counts, shadows, o_rd_data, o_match and o_overflow are 0.
- Per-channel priority on each rising edge: clear > load > count > hold.
  - clear: count <= 0.
  - load: count <= i_load_value.
  - count (enable=1): count <= count +1 (up) or -1 (down).
  - hold: enable=0, count unchanged.
- Arithmetic is modulo 2^DATA_WIDTH, unsigned.
- Wrap mode (SATURATE=0): up from all-ones gives 0; down from 0 gives all-ones.
- Saturate mode (SATURATE=1): up at all-ones holds all-ones; down at 0 holds 0.
- Overflow event:
  - Defined as a count step that wraps (wrap mode) or is blocked by a limit (saturate mode).
  - Sets o_overflow[i] at the same edge the event occurs.
  - o_overflow stays set until i_ovf_ack[i] or i_clear[i].
  - A set event in the same cycle as ack or clear wins: the flag stays 1.
  - A load never sets the overflow flag.
- Compare match:
  - o_match[i] is registered.
  - It is high for exactly one cycle after an edge where a count step (not a load or clear) makes the new count equal i_compare_value.
  - It is not asserted while the channel holds a matching value.
  - A saturate-blocked step does not produce a match.
- Snapshot:
  - On an edge with i_snapshot=1, every shadow[i] captures count[i]'s value before that edge, atomically for all channels.
  - A simultaneous clear, load or count applies to the live count only.
- Readback:
  - o_rd_data <= shadow[i_rd_sel] every edge, giving 1-cycle latency.
  - Snapshot and read in the same cycle returns the old shadow value; the new value appears the following cycle.
  - i_rd_sel >= NUM_CH returns 0.
- Reset asserted mid-count forces all state to 0 immediately, independent of clock.
- Counting resumes on the first edge after reset deasserts.

Decomposition:
- Shared package holds:
  - Step-direction constants UP=0, DOWN=1.
  - Mode constants WRAP=0, SAT=1.
  - Default width/channel constants.
- Natural sub-module: counter_channel.
  - Contains one count register, the priority logic, the overflow flag and the match pulse.
  - Instantiated NUM_CH times in a generate loop.
- The top level holds the shadow array and the read mux.

Test Plan:
- Reset then i_enable=4'b0001, up, 5 cycles: ch0 count=5. i_snapshot, then i_rd_sel=0: o_rd_data=5 one cycle after select. Other channels read 0.
- Load 32'hFFFF_FFFE into ch1 and count up 3 cycles, SATURATE=0: count sequence FFFF_FFFF, 0, 1. o_overflow[1] rises at the wrap edge and stays 1. Pulse i_ovf_ack[1] and it returns to 0.
- SATURATE=1, ch2 at 0 counting down 2 cycles: count stays 0 and o_overflow[2]=1. Repeat with i_ovf_ack asserted in the same cycle as the blocked step: the flag remains 1.
- i_compare_value=10, ch3 counting up from 8: o_match[3] is a single pulse one cycle after the count reaches 10. Load 10 directly: no pulse. Hold at 10 with enable=0: no further pulses.
- Assert i_clear and i_load together on ch0 while enabled: count=0. In the same cycle, assert i_snapshot with count at 7: shadow0=7 and the live count is 0.
- Assert i_reset asynchronously between edges while counting: all outputs are 0 before the next clock edge. i_rd_sel=3 with NUM_CH=3 returns o_rd_data=0.
